// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit path:
//   UART_BYTE_W      - width of one UART character (8)
//   XOR_MAX_BYTES    - widest word xor_reduce_bytes can fold
//   sender_state_t   - state encoding of the word sender FSM
//   xor_reduce_bytes - 8-bit XOR of all bytes of a (zero-extended) word
// ---------------------------------------------------------------------------
package uart_tx_pkg;

  localparam int UART_BYTE_W   = 8;
  localparam int XOR_MAX_BYTES = 32;
  localparam int XOR_MAX_W     = UART_BYTE_W * XOR_MAX_BYTES;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SEND  = 3'd2,
    GUARD = 3'd3,
    WAIT  = 3'd4
  } sender_state_t;

  // Zero bytes above the real payload do not change the XOR, so callers
  // simply zero-extend their word to XOR_MAX_W.
  function automatic logic [UART_BYTE_W-1:0] xor_reduce_bytes(
    input logic [XOR_MAX_W-1:0] data
  );
    logic [UART_BYTE_W-1:0] acc;
    acc = 8'h00;
    for (int i = 0; i < XOR_MAX_BYTES; i++) begin
      acc = acc ^ data[i*UART_BYTE_W +: UART_BYTE_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_word_sender_if.sv
// ---------------------------------------------------------------------------
// uart_word_sender_if
// Bundles the datapath request side and the UART transmitter handshake of
// the word sender.
//   trigger  - request to send raw_data (datapath -> sender)
//   raw_data - word to send, 8*DATA_BYTES bits (datapath -> sender)
//   tx_busy  - UART transmitter busy (transmitter -> sender)
//   tx_start - one-cycle start pulse (sender -> transmitter)
//   tx_data  - byte to transmit (sender -> transmitter)
//   busy     - sender not idle (sender -> datapath)
//   done     - frame complete pulse (sender -> datapath)
// Modports: master = the sender itself, slave = its environment.
// ---------------------------------------------------------------------------
interface uart_word_sender_if #(
  parameter int DATA_BYTES = 2
);
  import uart_tx_pkg::*;

  logic                              trigger;
  logic [UART_BYTE_W*DATA_BYTES-1:0] raw_data;
  logic                              tx_busy;
  logic                              tx_start;
  logic [UART_BYTE_W-1:0]            tx_data;
  logic                              busy;
  logic                              done;

  modport master (
    input  trigger, raw_data, tx_busy,
    output tx_start, tx_data, busy, done
  );

  modport slave (
    output trigger, raw_data, tx_busy,
    input  tx_start, tx_data, busy, done
  );

endinterface

// File: rtl/uart_word_sender.sv
// ---------------------------------------------------------------------------
// uart_word_sender
// Captures a DATA_BYTES-wide word on trigger and streams it to a UART
// transmitter as a frame: [header] payload bytes [XOR checksum].
// Parameters:
//   DATA_BYTES  - payload bytes (>= 1, <= 32)
//   MSB_FIRST   - 0: least-significant payload byte first, 1: most first
//   HEADER_EN   - 1: prepend HEADER_BYTE
//   HEADER_BYTE - header value
//   CHECKSUM_EN - 1: append XOR of the payload bytes
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - uart_word_sender_if.master (trigger/raw_data/tx_busy in,
//           tx_start/tx_data/busy/done out)
// tx_start, tx_data and done are registered; busy is decoded from state.
// ---------------------------------------------------------------------------
module uart_word_sender
  import uart_tx_pkg::*;
#(
  parameter int                     DATA_BYTES  = 2,
  parameter int                     MSB_FIRST   = 0,
  parameter int                     HEADER_EN   = 0,
  parameter logic [UART_BYTE_W-1:0] HEADER_BYTE = 8'hAA,
  parameter int                     CHECKSUM_EN = 0
) (
  input  logic               clk,
  input  logic               reset,
  uart_word_sender_if.master bus
);

  localparam int HDR_N     = (HEADER_EN != 0) ? 1 : 0;
  localparam int CSUM_N    = (CHECKSUM_EN != 0) ? 1 : 0;
  localparam int FRAME_LEN = HDR_N + DATA_BYTES + CSUM_N;
  localparam int IDX_W     = $clog2(FRAME_LEN + 1);
  localparam int WORD_W    = UART_BYTE_W * DATA_BYTES;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_LOAD  = LOAD;
  localparam logic [2:0] S_SEND  = SEND;
  localparam logic [2:0] S_GUARD = GUARD;
  localparam logic [2:0] S_WAIT  = WAIT;

  logic [2:0]             state_r;
  logic [IDX_W-1:0]       idx_r;
  logic [WORD_W-1:0]      word_r;
  logic [UART_BYTE_W-1:0] csum_r;
  logic                   tx_start_r;
  logic [UART_BYTE_W-1:0] tx_data_r;
  logic                   done_r;

  logic [UART_BYTE_W-1:0] frame_s [FRAME_LEN];
  logic [UART_BYTE_W-1:0] byte_sel_s;

  // Lay out the whole frame from the captured word: every slot starts as
  // the checksum (only the last slot keeps it when enabled), slot 0 takes
  // the header when enabled, then the payload bytes overwrite their slots.
  always_comb begin
    for (int p = 0; p < FRAME_LEN; p++) begin
      frame_s[p] = ((p == 0) && (HDR_N != 0)) ? HEADER_BYTE : csum_r;
    end
    for (int k = 0; k < DATA_BYTES; k++) begin
      frame_s[HDR_N + k] =
        word_r[UART_BYTE_W*((MSB_FIRST != 0) ? (DATA_BYTES - 1 - k) : k) +: UART_BYTE_W];
    end
  end

  // Pick the frame byte addressed by the running index.
  always_comb begin
    byte_sel_s = 8'h00;
    for (int p = 0; p < FRAME_LEN; p++) begin
      byte_sel_s = (idx_r == IDX_W'(p)) ? frame_s[p] : byte_sel_s;
    end
  end

  // Frame sequencer and registered transmitter-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      idx_r      <= {IDX_W{1'b0}};
      word_r     <= {WORD_W{1'b0}};
      csum_r     <= 8'h00;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
      done_r     <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // The done cycle still belongs to the finished frame, so a
          // trigger coinciding with done is dropped.
          if (bus.trigger && !done_r) begin
            state_r <= S_LOAD;
          end
        end
        S_LOAD: begin
          word_r  <= bus.raw_data;
          csum_r  <= xor_reduce_bytes(XOR_MAX_W'(bus.raw_data));
          idx_r   <= {IDX_W{1'b0}};
          state_r <= S_SEND;
        end
        S_SEND: begin
          if (!bus.tx_busy) begin
            tx_start_r <= 1'b1;
            tx_data_r  <= byte_sel_s;
            state_r    <= S_GUARD;
          end
        end
        S_GUARD: begin
          // The transmitter raises tx_busy one cycle after tx_start; skip
          // that cycle so WAIT never mistakes it for completion.
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.tx_busy) begin
            if (idx_r == LAST_IDX) begin
              done_r  <= 1'b1;
              state_r <= S_IDLE;
            end else begin
              idx_r   <= idx_r + IDX_W'(1'b1);
              state_r <= S_SEND;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_start = tx_start_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.done     = done_r;
  assign bus.busy     = (state_r != S_IDLE);

endmodule
